// File: rtl/demodulador_hw.sv
// Recovers a signed 8-bit value per phase from three 2-bit gate-drive codes over a
// fixed window of WIN cycles, and latches a sticky fault on shoot-through codes.
module demodulador_hw #(
  parameter int unsigned WIN   = 256,
  parameter int unsigned SHIFT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] in1,
  input  logic [1:0] in2,
  input  logic [1:0] in3,
  output logic [7:0] dem1,
  output logic [7:0] dem2,
  output logic [7:0] dem3,
  output logic       valid,
  output logic       fault
);

  localparam int unsigned CW = $clog2(WIN);
  localparam int unsigned AW = CW + 2;

  logic [CW-1:0]        r_cnt;
  logic signed [AW-1:0] r_acc [3];
  logic [7:0]           r_dem [3];
  logic                 r_valid;
  logic                 r_fault;

  logic [1:0]           w_in   [3];
  logic signed [AW-1:0] w_code [3];
  logic signed [AW-1:0] w_fin  [3];
  logic [7:0]           w_sat  [3];
  logic                 w_end;
  logic                 w_bad;

  // Clamp the shifted window sum into the signed 8-bit output range.
  function automatic logic [7:0] sat8(input logic signed [AW-1:0] v);
    logic signed [31:0] e;
    e = 32'(v);
    if (e > 32'sd127)       return 8'h7f;
    else if (e < -32'sd128) return 8'h80;
    else                    return e[7:0];
  endfunction

  always_comb begin
    w_in[0] = in1;
    w_in[1] = in2;
    w_in[2] = in3;
    w_end   = (r_cnt == CW'(WIN - 1));
    w_bad   = (&in1) | (&in2) | (&in3);
    for (int i = 0; i < 3; i++) begin
      w_code[i] = '0;
      case (w_in[i])
        2'b10:   w_code[i] = AW'(1);
        2'b01:   w_code[i] = '1;
        default: w_code[i] = '0;
      endcase
      w_fin[i] = r_acc[i] + w_code[i];
      w_sat[i] = sat8(w_fin[i] >>> SHIFT);
    end
  end

  // Window end includes the current sample, then restarts the accumulators.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_fault <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        r_acc[i] <= '0;
        r_dem[i] <= '0;
      end
    end else begin
      r_cnt   <= r_cnt + CW'(1);
      r_valid <= w_end;
      r_fault <= r_fault | w_bad;
      for (int i = 0; i < 3; i++) begin
        if (w_end) begin
          r_acc[i] <= '0;
          r_dem[i] <= w_sat[i];
        end else begin
          r_acc[i] <= w_fin[i];
        end
      end
    end
  end

  assign dem1  = r_dem[0];
  assign dem2  = r_dem[1];
  assign dem3  = r_dem[2];
  assign valid = r_valid;
  assign fault = r_fault;

endmodule

// File: tb/tb_demodulador_hw.sv
// Randomized and directed bench for demodulador_hw against a per-window sum model.
module tb_demodulador_hw;

  localparam int WIN   = 256;
  localparam int SHIFT = 1;

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        in1, in2, in3;
  logic signed [7:0] dem1, dem2, dem3;
  logic              valid, fault;

  int total = 0;
  int bad   = 0;

  int m_sum [3];
  int m_dem [3];
  int m_edges;
  bit m_valid;
  bit m_fault;
  int cyc    = 0;
  int prev_v = -1;

  demodulador_hw #(.WIN(WIN), .SHIFT(SHIFT)) dut (
    .clk(clk), .rst(rst),
    .in1(in1), .in2(in2), .in3(in3),
    .dem1(dem1), .dem2(dem2), .dem3(dem3),
    .valid(valid), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int code_val(input logic [1:0] c);
    if (c == 2'b10) return 1;
    if (c == 2'b01) return -1;
    return 0;
  endfunction

  // Floor division by 2**SHIFT, then clamp to -128..127.
  function automatic int expect_dem(input int s);
    int d, q;
    d = 1 << SHIFT;
    q = s / d;
    if ((s % d != 0) && (s < 0)) q = q - 1;
    if (q > 127)  q = 127;
    if (q < -128) q = -128;
    return q;
  endfunction

  task automatic step(input logic [1:0] a, input logic [1:0] b, input logic [1:0] c,
                      input bit r);
    logic [1:0] codes [3];
    codes[0] = a; codes[1] = b; codes[2] = c;
    in1 = a; in2 = b; in3 = c; rst = r;
    @(posedge clk);
    cyc++;
    if (r) begin
      m_edges = 0; m_valid = 0; m_fault = 0;
      for (int i = 0; i < 3; i++) begin m_sum[i] = 0; m_dem[i] = 0; end
    end else begin
      m_edges++;
      m_valid = 0;
      for (int i = 0; i < 3; i++) begin
        m_sum[i] += code_val(codes[i]);
        if (codes[i] == 2'b11) m_fault = 1;
      end
      if (m_edges == WIN) begin
        m_edges = 0;
        m_valid = 1;
        for (int i = 0; i < 3; i++) begin
          m_dem[i] = expect_dem(m_sum[i]);
          m_sum[i] = 0;
        end
      end
    end
    #1;
    chk("valid", int'(valid), int'(m_valid));
    chk("fault", int'(fault), int'(m_fault));
    chk("dem1", int'(dem1), m_dem[0]);
    chk("dem2", int'(dem2), m_dem[1]);
    chk("dem3", int'(dem3), m_dem[2]);
    if (r) prev_v = -1;
    else if (valid) begin
      if (prev_v >= 0) chk("valid_spacing", cyc - prev_v, WIN);
      prev_v = cyc;
    end
  endtask

  function automatic logic [1:0] rnd_code(input int p_hi, input int p_lo);
    int x;
    x = int'($urandom_range(0, 99));
    if (x < p_hi)        return 2'b10;
    if (x < p_hi + p_lo) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [1:0] pwm(input int m, input int i);
    return (i < 128 + m) ? 2'b10 : 2'b01;
  endfunction

  initial begin
    int mods [3];
    int ph [3];
    mods[0] = 60; mods[1] = -60; mods[2] = 0;
    in1 = 2'b00; in2 = 2'b00; in3 = 2'b00; rst = 1'b1;
    step(2'b00, 2'b00, 2'b00, 1'b1);
    step(2'b00, 2'b00, 2'b00, 1'b1);

    // Full-scale positive on phase 1.
    for (int i = 0; i < WIN; i++) step(2'b10, 2'b00, 2'b00, 1'b0);
    // Full-scale negative on phase 2, alternating on phase 3.
    for (int i = 0; i < WIN; i++) step(2'b00, 2'b01, (i % 2 == 0) ? 2'b10 : 2'b01, 1'b0);
    // 192 up / 64 down, then 64 up / 128 off / 64 down.
    for (int i = 0; i < WIN; i++) step((i < 192) ? 2'b10 : 2'b01, 2'b00, 2'b00, 1'b0);
    for (int i = 0; i < WIN; i++)
      step((i < 64) ? 2'b10 : ((i < 192) ? 2'b00 : 2'b01), 2'b00, 2'b00, 1'b0);
    // Single shoot-through sample mid-window, then a clean window.
    for (int i = 0; i < WIN; i++)
      step(rnd_code(50, 30), rnd_code(20, 60), (i == 100) ? 2'b11 : 2'b10, 1'b0);
    for (int i = 0; i < WIN; i++) step(rnd_code(40, 40), 2'b00, 2'b01, 1'b0);
    // Reset mid-window after a partial sum, then a window of zeros.
    for (int i = 0; i < 100; i++) step(2'b10, 2'b10, 2'b01, 1'b0);
    step(2'b10, 2'b10, 2'b10, 1'b1);
    for (int i = 0; i < WIN + 4; i++) step(2'b00, 2'b00, 2'b00, 1'b0);
    // Modulator-style PWM patterns at three settings, rotated across phases.
    for (int k = 0; k < 3; k++) begin
      for (int p = 0; p < 3; p++) ph[p] = mods[(k + p) % 3];
      for (int w = 0; w < 2; w++)
        for (int i = 0; i < WIN; i++)
          step(pwm(ph[0], (i + WIN - 4) % WIN), pwm(ph[1], (i + WIN - 4) % WIN),
               pwm(ph[2], (i + WIN - 4) % WIN), 1'b0);
    end
    // Random windows with per-window biases, including rare shoot-through codes.
    step(2'b00, 2'b00, 2'b00, 1'b1);
    for (int w = 0; w < 10; w++) begin
      int b1, b2, b3;
      b1 = int'($urandom_range(0, 100));
      b2 = int'($urandom_range(0, 100));
      b3 = int'($urandom_range(0, 100));
      for (int i = 0; i < WIN; i++) begin
        logic [1:0] c3;
        c3 = rnd_code(b3, 100 - b3);
        if ($urandom_range(0, 999) == 0) c3 = 2'b11;
        step(rnd_code(b1, 100 - b1), rnd_code(b2 / 2, b2 / 2), c3, 1'b0);
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
